// File: rtl/guess_game_ctrl_if.sv
// Signal bundle between the guess-game controller and the board-side logic
// (switches, random source, display and beeper drivers).
interface guess_game_ctrl_if #(
  parameter int unsigned GW = 7
);
  logic          en;
  logic          new_game;
  logic          submit;
  logic          tick;
  logic [GW-1:0] guess;
  logic [GW-1:0] rand_val;
  logic [2:0]    state;
  logic [3:0]    level;
  logic [GW-1:0] target;
  logic [3:0]    tries_left;
  logic [7:0]    time_left;
  logic          correct_pulse;
  logic          wrong_pulse;
  logic          win;
  logic          lose;

  modport master (
    output en, new_game, submit, tick, guess, rand_val,
    input  state, level, target, tries_left, time_left,
    input  correct_pulse, wrong_pulse, win, lose
  );

  modport slave (
    input  en, new_game, submit, tick, guess, rand_val,
    output state, level, target, tries_left, time_left,
    output correct_pulse, wrong_pulse, win, lose
  );
endinterface

// File: rtl/guess_game_ctrl.sv
// Multi-round switch-guessing game controller: per-round target, limited
// attempts, per-attempt countdown on an external 1 Hz tick.
module guess_game_ctrl #(
  parameter int unsigned LEVELS    = 3,
  parameter int unsigned BASE_W    = 5,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned TIME_S    = 10
) (
  input logic              clk,
  input logic              rst,
  guess_game_ctrl_if.slave bus
);
  localparam int unsigned GW = BASE_W + LEVELS - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    LOAD  = 3'd2,
    PLAY  = 3'd3,
    JUDGE = 3'd4,
    WIN   = 3'd5,
    LOSE  = 3'd6
  } state_t;

  state_t        state_q, state_n;
  logic [3:0]    level_q, level_n;
  logic [GW-1:0] target_q, target_n;
  logic [GW-1:0] guess_q, guess_n;
  logic          timeout_q, timeout_n;
  logic [3:0]    tries_q, tries_n;
  logic [7:0]    time_q, time_n;
  logic          correct_q, correct_n;
  logic          wrong_q, wrong_n;
  logic          win_q, lose_q;

  // Bits below BASE_W+lvl are live for the given round
  function automatic logic [GW-1:0] lvl_mask(input logic [3:0] lvl);
    logic [GW-1:0] m;
    for (int unsigned i = 0; i < GW; i++) begin
      m[i] = (i < BASE_W + 32'(lvl));
    end
    return m;
  endfunction

  always_comb begin
    state_n   = state_q;
    level_n   = level_q;
    target_n  = target_q;
    guess_n   = guess_q;
    timeout_n = timeout_q;
    tries_n   = tries_q;
    time_n    = time_q;
    correct_n = 1'b0;
    wrong_n   = 1'b0;

    if (!bus.en) begin
      state_n = IDLE;
    end else if (bus.new_game && (state_q != IDLE) && (state_q != LOAD)) begin
      state_n = LOAD;
      level_n = 4'd0;
    end else begin
      unique case (state_q)
        IDLE:  state_n = READY;
        READY: state_n = READY;
        LOAD: begin
          target_n = bus.rand_val & lvl_mask(level_q);
          tries_n  = 4'(MAX_TRIES);
          time_n   = 8'(TIME_S);
          state_n  = PLAY;
        end
        PLAY: begin
          // submit has priority; a coincident tick is dropped
          if (bus.submit) begin
            guess_n   = bus.guess & lvl_mask(level_q);
            timeout_n = 1'b0;
            state_n   = JUDGE;
          end else if (bus.tick) begin
            if (time_q == 8'd1) begin
              time_n    = 8'd0;
              timeout_n = 1'b1;
              state_n   = JUDGE;
            end else begin
              time_n = time_q - 8'd1;
            end
          end
        end
        JUDGE: begin
          if (!timeout_q && (guess_q == target_q)) begin
            correct_n = 1'b1;
            if (level_q == 4'(LEVELS - 1)) begin
              state_n = WIN;
            end else begin
              level_n = level_q + 4'd1;
              state_n = LOAD;
            end
          end else begin
            wrong_n = 1'b1;
            tries_n = tries_q - 4'd1;
            if (tries_q == 4'd1) begin
              state_n = LOSE;
            end else begin
              time_n  = 8'(TIME_S);
              state_n = PLAY;
            end
          end
        end
        WIN:     state_n = WIN;
        LOSE:    state_n = LOSE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      level_q   <= 4'd0;
      target_q  <= '0;
      guess_q   <= '0;
      timeout_q <= 1'b0;
      tries_q   <= 4'd0;
      time_q    <= 8'd0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      level_q   <= level_n;
      target_q  <= target_n;
      guess_q   <= guess_n;
      timeout_q <= timeout_n;
      tries_q   <= tries_n;
      time_q    <= time_n;
      correct_q <= correct_n;
      wrong_q   <= wrong_n;
      win_q     <= (state_n == WIN);
      lose_q    <= (state_n == LOSE);
    end
  end

  assign bus.state         = state_q;
  assign bus.level         = level_q;
  assign bus.target        = target_q;
  assign bus.tries_left    = tries_q;
  assign bus.time_left     = time_q;
  assign bus.correct_pulse = correct_q;
  assign bus.wrong_pulse   = wrong_q;
  assign bus.win           = win_q;
  assign bus.lose          = lose_q;
endmodule
